// File: rtl/burst_master_port.sv
// Burst master for the shared bit-serial bus: wins arbitration, sends slave select and address, then streams 1..2^BURST_W beats.
// Build option: define MASTER_TIMEOUT_EN to abort any wait that lasts TIMEOUT cycles.
module burst_master_port #(
  parameter int SLAVE_LEN = 2,
  parameter int ADDR_LEN  = 12,
  parameter int DATA_LEN  = 8,
  parameter int BURST_W   = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [SLAVE_LEN-1:0] cmd_slave,
  input  logic [ADDR_LEN-1:0]  cmd_addr,
  input  logic [BURST_W-1:0]   cmd_len,
  input  logic [DATA_LEN-1:0]  wr_data,
  output logic                 wr_data_req,
  output logic [DATA_LEN-1:0]  rd_data,
  output logic                 rd_valid,
  output logic                 done,
  output logic                 error,
  output logic                 approval_request,
  input  logic                 approval_grant,
  input  logic                 bus_busy,
  output logic                 tx_slave_select,
  output logic                 tx_address,
  output logic                 tx_data,
  input  logic                 rx_data,
  output logic                 master_valid,
  output logic                 master_ready,
  input  logic                 slave_valid,
  input  logic                 slave_ready,
  output logic                 write_en,
  output logic                 read_en,
  output logic                 trans_done,
  output logic [3:0]           o_dbg_state
);

  localparam int MAX_AD = (ADDR_LEN > DATA_LEN) ? ADDR_LEN : DATA_LEN;
  localparam int MAX_LEN = (MAX_AD > SLAVE_LEN) ? MAX_AD : SLAVE_LEN;
  localparam int CNT_W = $clog2(MAX_LEN + 1);
  localparam logic [CNT_W-1:0] SEL_LAST  = CNT_W'(SLAVE_LEN - 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_LEN - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_LEN - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_REQ, S_SEL, S_ADDR, S_WFETCH, S_WDATA, S_RDATA, S_DONE, S_ABORT
  } state_t;

  state_t               r_state, w_next;
  logic                 r_write;
  logic [BURST_W-1:0]   r_len, r_beat;
  logic [CNT_W-1:0]     r_bit;
  logic [SLAVE_LEN-1:0] r_sel_sh;
  logic [ADDR_LEN-1:0]  r_addr_sh;
  logic [DATA_LEN-1:0]  r_wr_sh, r_rd_sh, r_rd_data;
  logic                 r_rd_valid;
  logic                 w_go, w_last, w_wait, w_owned, w_adv, w_beat_last;
  logic [DATA_LEN-1:0]  w_rd_next;

  assign o_dbg_state = r_state;
  assign rd_data     = r_rd_data;
  assign rd_valid    = r_rd_valid;
  assign w_beat_last = (r_beat == r_len);
  assign w_rd_next   = {r_rd_sh[DATA_LEN-2:0], rx_data};
  assign w_adv       = w_go && (w_next != S_ABORT);

`ifdef MASTER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  logic [TO_W-1:0] r_wait;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_wait <= '0;
    else if (w_wait && (w_next != S_ABORT)) r_wait <= r_wait + 1'b1;
    else r_wait <= '0;
  end
`else
  logic w_unused;
  assign w_unused = w_wait ^ (TIMEOUT == 0);
`endif

  // Serial handshake: a field starts only when the partner's flag (slave_ready for
  // address/write bits, slave_valid for read bits) is high in the cycle of its first
  // bit; the remaining bits then move one per cycle with no further flow control.
  always_comb begin
    w_next           = r_state;
    cmd_ready        = 1'b0;
    approval_request = 1'b0;
    wr_data_req      = 1'b0;
    tx_slave_select  = 1'b0;
    tx_address       = 1'b0;
    tx_data          = 1'b0;
    master_valid     = 1'b0;
    master_ready     = 1'b0;
    write_en         = 1'b0;
    read_en          = 1'b0;
    done             = 1'b0;
    error            = 1'b0;
    trans_done       = 1'b0;
    w_go             = 1'b0;
    w_last           = 1'b0;
    w_wait           = 1'b0;
    w_owned          = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) w_next = S_REQ;
      end
      S_REQ: begin
        approval_request = 1'b1;
        if (approval_grant && !bus_busy) w_next = S_SEL;
        else w_wait = 1'b1;
      end
      S_SEL: begin
        approval_request = 1'b1;
        w_owned          = 1'b1;
        w_go             = 1'b1;
        w_last           = (r_bit == SEL_LAST);
        tx_slave_select  = r_sel_sh[SLAVE_LEN-1];
        if (w_last) w_next = S_ADDR;
      end
      S_ADDR: begin
        approval_request = 1'b1;
        w_owned          = 1'b1;
        write_en         = r_write;
        read_en          = !r_write;
        w_go             = (r_bit != '0) || slave_ready;
        w_wait           = !w_go;
        w_last           = (r_bit == ADDR_LAST);
        if (w_go) begin
          master_valid = 1'b1;
          tx_address   = r_addr_sh[ADDR_LEN-1];
          if (w_last) w_next = r_write ? S_WFETCH : S_RDATA;
        end
      end
      S_WFETCH: begin
        approval_request = 1'b1;
        w_owned          = 1'b1;
        write_en         = 1'b1;
        wr_data_req      = 1'b1;
        w_next           = S_WDATA;
      end
      S_WDATA: begin
        approval_request = 1'b1;
        w_owned          = 1'b1;
        write_en         = 1'b1;
        w_go             = (r_bit != '0) || slave_ready;
        w_wait           = !w_go;
        w_last           = (r_bit == DATA_LAST);
        if (w_go) begin
          master_valid = 1'b1;
          tx_data      = r_wr_sh[DATA_LEN-1];
          if (w_last) w_next = w_beat_last ? S_DONE : S_WFETCH;
        end
      end
      S_RDATA: begin
        approval_request = 1'b1;
        w_owned          = 1'b1;
        read_en          = 1'b1;
        master_ready     = 1'b1;
        w_go             = (r_bit != '0) || slave_valid;
        w_wait           = !w_go;
        w_last           = (r_bit == DATA_LAST);
        if (w_go && w_last) w_next = w_beat_last ? S_DONE : S_RDATA;
      end
      S_DONE: begin
        approval_request = 1'b1;
        done             = 1'b1;
        trans_done       = 1'b1;
        w_next           = S_IDLE;
      end
      S_ABORT: begin
        error      = 1'b1;
        trans_done = 1'b1;
        w_next     = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (w_owned && !approval_grant) w_next = S_ABORT;
`ifdef MASTER_TIMEOUT_EN
    if (w_wait && (r_wait == TO_LAST)) w_next = S_ABORT;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_write    <= 1'b0;
      r_len      <= '0;
      r_beat     <= '0;
      r_bit      <= '0;
      r_sel_sh   <= '0;
      r_addr_sh  <= '0;
      r_wr_sh    <= '0;
      r_rd_sh    <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_rd_valid <= 1'b0;
      if ((r_state == S_IDLE) && cmd_valid) begin
        r_write   <= cmd_write;
        r_len     <= cmd_len;
        r_sel_sh  <= cmd_slave;
        r_addr_sh <= cmd_addr;
        r_beat    <= '0;
        r_bit     <= '0;
      end
      if (r_state == S_WFETCH) r_wr_sh <= wr_data;
      if (w_adv) begin
        r_bit <= w_last ? '0 : r_bit + 1'b1;
        case (r_state)
          S_SEL:   r_sel_sh  <= r_sel_sh << 1;
          S_ADDR:  r_addr_sh <= r_addr_sh << 1;
          S_WDATA: r_wr_sh   <= r_wr_sh << 1;
          S_RDATA: begin
            r_rd_sh <= w_rd_next;
            if (w_last) begin
              r_rd_data  <= w_rd_next;
              r_rd_valid <= 1'b1;
            end
          end
          default: ;
        endcase
        // Compare before incrementing so an all-ones length never wraps the counter.
        if (w_last && ((r_state == S_WDATA) || (r_state == S_RDATA)) && !w_beat_last)
          r_beat <= r_beat + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_burst_master_port.sv
// Bench for burst_master_port: cycle table for a single write, scoreboarded read/write bursts,
// and hand-written sequences for bus_busy, grant loss, wait timeout and asynchronous reset.
`timescale 1ns/1ps
module tb_burst_master_port;
  localparam int SL = 2, AL = 12, DL = 8, BW = 4, TO = 20;

  logic          clk, reset;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [SL-1:0] cmd_slave;
  logic [AL-1:0] cmd_addr;
  logic [BW-1:0] cmd_len;
  logic [DL-1:0] wr_data, rd_data;
  logic          wr_data_req, rd_valid, done, error;
  logic          approval_request, approval_grant, bus_busy;
  logic          tx_slave_select, tx_address, tx_data, rx_data;
  logic          master_valid, master_ready, slave_valid, slave_ready;
  logic          write_en, read_en, trans_done;
  logic [3:0]    dbg_state;

  burst_master_port #(.SLAVE_LEN(SL), .ADDR_LEN(AL), .DATA_LEN(DL), .BURST_W(BW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_slave(cmd_slave), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wr_data(wr_data),
    .wr_data_req(wr_data_req), .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .error(error),
    .approval_request(approval_request), .approval_grant(approval_grant), .bus_busy(bus_busy),
    .tx_slave_select(tx_slave_select), .tx_address(tx_address), .tx_data(tx_data), .rx_data(rx_data),
    .master_valid(master_valid), .master_ready(master_ready), .slave_valid(slave_valid),
    .slave_ready(slave_ready), .write_en(write_en), .read_en(read_en), .trans_done(trans_done),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int            n_checks = 0, n_fail = 0;
  logic [DL-1:0] exp_q[$];
  int            cnt_req = 0, cnt_rdv = 0, cnt_done = 0, cnt_err = 0, cnt_wbeat = 0;
  bit            wr_fixed_en = 0;
  logic [DL-1:0] wr_fixed = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] obs();
    return {cmd_ready, approval_request, tx_slave_select, tx_address, tx_data,
            master_valid, wr_data_req, done, trans_done, write_en};
  endfunction

  function automatic logic [21:0] obs_full();
    return {cmd_ready, approval_request, tx_slave_select, tx_address, tx_data, master_valid,
            master_ready, wr_data_req, rd_valid, done, error, write_en, read_en, trans_done, rd_data};
  endfunction

  // Write-data source: answers every request with a new beat and records it as expected.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (wr_data_req) begin
        wr_data = wr_fixed_en ? wr_fixed : DL'($urandom_range(0, 255));
        exp_q.push_back(wr_data);
      end
    end
  end

  // Monitor: rebuilds write beats off tx_data, compares them and read beats against exp_q.
  initial begin
    int            wbits;
    logic [DL-1:0] wbuf, e;
    wbits = 0;
    wbuf  = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (rd_valid) begin
          cnt_rdv++;
          if (exp_q.size() == 0) check("rd_unexpected", 64'(1), 64'(0));
          else begin
            e = exp_q.pop_front();
            check("rd_data", 64'(rd_data), 64'(e));
          end
        end
        if (wr_data_req) cnt_req++;
        if (done) cnt_done++;
        if (error) cnt_err++;
        if (write_en && master_valid) begin
          wbits++;
          if (wbits > AL) begin
            wbuf = {wbuf[DL-2:0], tx_data};
            if (((wbits - AL) % DL) == 0) begin
              cnt_wbeat++;
              if (exp_q.size() == 0) check("wr_unexpected", 64'(1), 64'(0));
              else begin
                e = exp_q.pop_front();
                check("wr_beat", 64'(wbuf), 64'(e));
              end
            end
          end
        end
        if (!write_en) wbits = 0;
      end else wbits = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue_cmd(input logic w, input logic [SL-1:0] s, input logic [AL-1:0] a,
                           input logic [BW-1:0] l);
    int t = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_slave = s; cmd_addr = a; cmd_len = l;
    while (!cmd_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 100) check("cmd_accept_timeout", 64'(0), 64'(1));
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_end(input int limit);
    int cyc = 0;
    bit seen = 0;
    while (!seen && cyc < limit) begin
      @(negedge clk);
      seen = done | error;
      cyc++;
    end
    if (!seen) check("end_timeout", 64'(0), 64'(1));
    @(posedge clk); #1;
  endtask

  task automatic slave_send(input logic [DL-1:0] v, input int gap);
    int t = 0;
    while (!master_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 200) check("rd_wait_timeout", 64'(0), 64'(1));
    repeat (gap) begin
      @(posedge clk); #1;
    end
    exp_q.push_back(v);
    for (int b = DL - 1; b >= 0; b--) begin
      slave_valid = 1'b1;
      rx_data     = v[b];
      @(posedge clk); #1;
    end
    slave_valid = 1'b0;
    rx_data     = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       grant;
    logic       sready;
    logic [9:0] exp;  // {cmd_ready, approval_request, tx_ss, tx_addr, tx_data, master_valid, wr_req, done, trans_done, write_en}
  } vec_t;
  vec_t tbl[26];

  // ---------------- main sequence ----------------
  initial begin
    logic [SL-1:0] s_v;
    logic [AL-1:0] a_v;
    logic [DL-1:0] d_v;
    logic [DL-1:0] rd_vals[4];
    int c0, d0, e0, r0, b0;

    s_v = 2'b10; a_v = 12'hA5C; d_v = 8'h3C;
    rd_vals[0] = 8'h11; rd_vals[1] = 8'h22; rd_vals[2] = 8'h33; rd_vals[3] = 8'h44;
    for (int k = 0; k < 26; k++) begin
      logic cr, ar, ss, ad, dd, mv, rq, dn, td, we;
      {cr, ar, ss, ad, dd, mv, rq, dn, td, we} = '0;
      if (k == 0) ar = 1'b1;
      else if (k <= 2) begin ar = 1'b1; ss = s_v[SL-k]; end
      else if (k <= 14) begin ar = 1'b1; we = 1'b1; mv = 1'b1; ad = a_v[AL-1-(k-3)]; end
      else if (k == 15) begin ar = 1'b1; we = 1'b1; rq = 1'b1; end
      else if (k <= 23) begin ar = 1'b1; we = 1'b1; mv = 1'b1; dd = d_v[DL-1-(k-16)]; end
      else if (k == 24) begin ar = 1'b1; dn = 1'b1; td = 1'b1; end
      else cr = 1'b1;
      tbl[k].grant  = 1'b1;
      tbl[k].sready = 1'b1;
      tbl[k].exp    = {cr, ar, ss, ad, dd, mv, rq, dn, td, we};
    end

    reset = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_slave = '0; cmd_addr = '0; cmd_len = '0;
    wr_data = '0; approval_grant = 1'b1; bus_busy = 1'b0; rx_data = 1'b0;
    slave_valid = 1'b0; slave_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", 64'(obs_full()), 64'(22'h200000));
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Single write, cycle-by-cycle against the table.
    wr_fixed_en = 1; wr_fixed = d_v;
    issue_cmd(1'b1, s_v, a_v, 4'd0);
    for (int k = 0; k < 26; k++) begin
      approval_grant = tbl[k].grant;
      slave_ready    = tbl[k].sready;
      @(negedge clk);
      check($sformatf("wr1_cyc%0d", k), 64'(obs()), 64'(tbl[k].exp));
      @(posedge clk); #1;
    end
    wr_fixed_en = 0;

    // Read burst of 4 beats with 5-cycle slave_valid gaps.
    c0 = cnt_rdv; d0 = cnt_done;
    issue_cmd(1'b0, 2'b01, 12'h123, 4'd3);
    for (int i = 0; i < 4; i++) slave_send(rd_vals[i], 5);
    wait_end(200);
    check("rd_pulses", 64'(cnt_rdv - c0), 64'(4));
    check("rd_done", 64'(cnt_done - d0), 64'(1));

    // Maximum-length write burst.
    r0 = cnt_req; b0 = cnt_wbeat; d0 = cnt_done;
    issue_cmd(1'b1, 2'b11, 12'h0F0, 4'hF);
    wait_end(1000);
    check("burst_req", 64'(cnt_req - r0), 64'(16));
    check("burst_beats", 64'(cnt_wbeat - b0), 64'(16));
    check("burst_done", 64'(cnt_done - d0), 64'(1));

    // bus_busy holds the master in REQ while grant is already high.
    bus_busy = 1'b1;
    issue_cmd(1'b1, 2'b11, 12'h555, 4'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("busy_quiet%0d", i),
            64'({approval_request, tx_slave_select, tx_address, tx_data, master_valid}), 64'(5'b10000));
      @(posedge clk); #1;
    end
    bus_busy = 1'b0;
    @(negedge clk);
    check("busy_fall_still_req", 64'({approval_request, tx_slave_select}), 64'(2'b10));
    @(posedge clk); #1;
    @(negedge clk);
    check("sel_starts", 64'(tx_slave_select), 64'(1));
    @(posedge clk); #1;
    wait_end(200);

    // Grant dropped while address bit 5 is on the wire.
    begin
      int mvc = 0, t = 0;
      d0 = cnt_done;
      issue_cmd(1'b1, 2'b01, 12'hFFF, 4'd2);
      while (mvc < 5 && t < 100) begin
        @(negedge clk);
        if (master_valid) mvc++;
        t++;
      end
      if (mvc < 5) check("gd_reach_addr", 64'(mvc), 64'(5));
      @(posedge clk); #1;
      approval_grant = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check("gd_abort", 64'({error, trans_done, done, cmd_ready}), 64'(4'b1100));
      @(posedge clk); #1;
      approval_grant = 1'b1;
      @(negedge clk);
      check("gd_idle", 64'({error, trans_done, done, cmd_ready}), 64'(4'b0001));
      @(posedge clk); #1;
      check("gd_no_done", 64'(cnt_done - d0), 64'(0));
    end

    // slave_ready held low in ADDR.
    slave_ready = 1'b0;
    e0 = cnt_err; d0 = cnt_done;
    issue_cmd(1'b1, 2'b10, 12'h321, 4'd0);
`ifdef MASTER_TIMEOUT_EN
    begin
      int k = 0;
      bit seen = 0;
      while (!seen && k < 100) begin
        @(negedge clk);
        if (error) seen = 1;
        else begin
          @(posedge clk); #1;
          k++;
        end
      end
      check("to_error_cycle", 64'(k), 64'(TO + 3));
      @(posedge clk); #1;
      slave_ready = 1'b1;
      @(negedge clk);
      check("to_idle", 64'(cmd_ready), 64'(1));
      @(posedge clk); #1;
    end
`else
    begin
      bit bad = 0;
      repeat (300) begin
        @(negedge clk);
        if (error | master_valid | done) bad = 1;
      end
      check("no_timeout", 64'(bad), 64'(0));
      check("still_in_addr", 64'({approval_request, write_en}), 64'(2'b11));
      @(posedge clk); #1;
      slave_ready = 1'b1;
      wait_end(200);
      check("wait_then_done", 64'({cnt_done - d0, cnt_err - e0}), 64'({32'd1, 32'd0}));
    end
`endif

    // Asynchronous reset in the middle of a read beat.
    begin
      int t = 0;
      c0 = cnt_rdv; d0 = cnt_done; e0 = cnt_err;
      issue_cmd(1'b0, 2'b00, 12'h0AA, 4'd3);
      while (!master_ready && t < 100) begin
        @(posedge clk); #1;
        t++;
      end
      if (t >= 100) check("rst_reach_rdata", 64'(0), 64'(1));
      for (int i = 0; i < 3; i++) begin
        slave_valid = 1'b1;
        rx_data     = i[0];
        @(posedge clk); #1;
      end
      #2;
      reset = 1'b0;
      #1;
      check("rst_mid_outputs", 64'(obs_full()), 64'(22'h200000));
      slave_valid = 1'b0;
      rx_data     = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      repeat (3) begin
        @(posedge clk); #1;
      end
      check("rst_silent", 64'({cnt_rdv - c0, cnt_done - d0}), 64'(0));
      check("rst_no_error", 64'(cnt_err - e0), 64'(0));
      check("rst_idle", 64'(cmd_ready), 64'(1));
    end

    check("exp_q_empty", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/burst_master_port.md
Name: burst_master_port

Overview:
Parametrised successor to the single-transfer serial master port. It accepts one command from local logic and arbitrates for the shared serial bus. It then serially sends slave select, address and 1..2^BURST_W data beats (write) or receives them (read), using the valid/ready bit-serial handshake. It sits between application logic (button/display or a processor front-end) and the bus arbiter/slave fabric.

Parameters:
SLAVE_LEN, 2, slave-select field width (bits)
ADDR_LEN, 12, address field width
DATA_LEN, 8, data beat width
BURST_W, 4, width of burst-length field; max beats = 2^BURST_W
TIMEOUT, 255, wait-cycle limit before abort (MASTER_TIMEOUT_EN only)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  block idle, command accepted when cmd_valid&cmd_ready
cmd_write  input  1  1=write burst, 0=read burst
cmd_slave  input  SLAVE_LEN  target slave
cmd_addr  input  ADDR_LEN  start address
cmd_len  input  BURST_W  beats minus one
wr_data  input  DATA_LEN  next write beat, sampled the cycle after wr_data_req
wr_data_req  output  1  one-cycle pulse requesting the next write beat
rd_data  output  DATA_LEN  last received read beat
rd_valid  output  1  one-cycle pulse, rd_data valid
done  output  1  one-cycle pulse, burst completed OK
error  output  1  one-cycle pulse, burst aborted
approval_request  output  1  bus request to arbiter
approval_grant  input  1  arbiter grant
bus_busy  input  1  bus occupied by another master
tx_slave_select  output  1  serial slave select, MSB first
tx_address  output  1  serial address, MSB first
tx_data  output  1  serial write data, MSB first
rx_data  input  1  serial read data, MSB first
master_valid  output  1  master driving valid serial bits
master_ready  output  1  master ready to receive read bits
slave_valid  input  1  slave driving valid read bits
slave_ready  input  1  slave ready for address/write bits
write_en  output  1  write transaction in progress
read_en  output  1  read transaction in progress
trans_done  output  1  one-cycle pulse to arbiter, bus released

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0 except cmd_ready=1; counters and shift registers cleared. Reset mid-burst aborts silently: no done, error or trans_done.
- IDLE: cmd_ready=1. On cmd_valid, latch all cmd_* fields, enter REQ. cmd_ready=0 in every other state.
- REQ: approval_request=1. When approval_grant=1 and bus_busy=0 in the same cycle, enter SEL. approval_request stays 1 until the cycle after trans_done.
- SEL: SLAVE_LEN cycles, one bit per cycle on tx_slave_select, MSB first. Enter ADDR.
- ADDR: write_en=cmd_write and read_en=~cmd_write from here until DONE. Hold until slave_ready=1. Then shift ADDR_LEN bits on tx_address with master_valid=1, one per cycle; slave_ready is not rechecked mid-field. Next state: WDATA for writes, RDATA for reads.
- WDATA (per beat): pulse wr_data_req and load wr_data the next cycle. Wait slave_ready=1, then shift DATA_LEN bits on tx_data with master_valid=1. The beat counter increments after the last bit. When counter==cmd_len, enter DONE; otherwise start the next beat.
- RDATA (per beat): master_ready=1. When slave_valid=1, sample rx_data for DATA_LEN consecutive cycles. On the cycle after the last bit, update rd_data and pulse rd_valid. Counter rules as in WDATA.
- DONE: pulse trans_done and done for one cycle; clear write_en, read_en and approval_request; return to IDLE. The earliest new command is accepted the following cycle.
- Address incrementing within a burst belongs to the slave; the master sends the address once. Wrap at 2^ADDR_LEN is not checked.
- Grant loss: approval_grant=0 in any state SEL..RDATA causes ABORT: one cycle with error=1 and trans_done=1, outputs cleared, then IDLE.
- cmd_len=0 gives a single beat. cmd_len=all-ones gives 2^BURST_W beats; the counter must be BURST_W+1 wide or compare before incrementing.
- Serial outputs are held 0 when their field is not active.
- Latency, 1-beat write with immediate grant/ready: 1 (REQ) + SLAVE_LEN + ADDR_LEN + 1 (fetch) + DATA_LEN + 1 (DONE) cycles from acceptance.

Optional Feature:
MASTER_TIMEOUT_EN: when defined, a wait counter runs in REQ, in the ADDR and WDATA slave_ready waits, and in the RDATA slave_valid wait. It clears on each exit from a wait. Reaching TIMEOUT cycles triggers ABORT (error+trans_done pulse, IDLE). When undefined, waits are unbounded and the counter logic is absent.

Test Plan:
- Single write: slave=2'b10, addr=12'hA5C, len=0, wr_data=8'h3C, immediate grant/ready -> tx_slave_select 1,0; tx_address 1010_0101_1100; tx_data 0011_1100; done and trans_done pulse at cycle 24 after acceptance.
- Read burst len=3: slave returns 8'h11,22,33,44 with slave_valid gaps of 5 cycles -> four rd_valid pulses with those values in order, then one done.
- Write burst len=4'hF -> exactly 16 wr_data_req pulses, 16 beats shifted, counter does not wrap early.
- bus_busy=1 for 10 cycles while grant=1 -> stays in REQ, no tx activity; SEL starts the cycle after bus_busy falls.
- Grant dropped during ADDR bit 5 -> error and trans_done pulse, IDLE next cycle, cmd_ready=1, no done.
- MASTER_TIMEOUT_EN, TIMEOUT=20, slave_ready held 0 in ADDR -> error after 20 cycles. Without the macro -> waits indefinitely. Separately, reset asserted mid-RDATA -> all outputs 0 and cmd_ready=1 immediately.
